// File: rtl/lsb_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : lsb_mem_ctrl
// Description : Data-side memory responder for the load-store buffer. Takes
//               one load/store at a time, requests the shared 8-bit RAM/IO
//               bus, and moves the data one byte per cycle.
//
//               Loads return a sign- or zero-extended result together with
//               a one-cycle cache_ready pulse. Stores write 1, 2 or 4 bytes
//               and then pulse cache_ready, with cache_data_out = 0.
//
// Ports       : clk, rst (async, active low), rdy (global stall enable),
//               rob_clear (pipeline flush)
//               LSB side : in_lsb_ready, op_in, instr_type_in, data_addr_in,
//                          data_in, welcome_lsb, cache_ready,
//                          cache_instr_type, cache_data_out
//               Bus side : mem_req, mem_gnt, mem_din, mem_dout, mem_a,
//                          mem_wr, io_buffer_full
//
// Option      : `define IO_STALL_EN
//               - IO stores wait while io_buffer_full is high.
//               - IO loads are done as a single byte.
//               When this macro is not defined, IO addresses are handled
//               exactly like RAM.
//
// Revision    : 1.0 - initial release
// ============================================================================
module lsb_mem_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int IO_BASE_BIT = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rob_clear,
    output logic                  welcome_lsb,
    input  logic                  in_lsb_ready,
    input  logic [2:0]            op_in,
    input  logic [6:0]            instr_type_in,
    input  logic [ADDR_WIDTH-1:0] data_addr_in,
    input  logic [31:0]           data_in,
    output logic                  cache_ready,
    output logic [6:0]            cache_instr_type,
    output logic [31:0]           cache_data_out,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    localparam logic [6:0] C_TYPE_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_GNT = 2'd1,
        S_XFER     = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                r_state, w_state_n;
    logic [2:0]            r_op, w_op_n;
    logic [6:0]            r_type, w_type_n;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
    logic [31:0]           r_data, w_data_n;
    logic [2:0]            r_nbytes, w_nbytes_n;
    logic [2:0]            r_k, w_k_n;
    logic [31:0]           r_bytes, w_bytes_n;
    logic                  r_cache_ready, w_cache_ready_n;
    logic [6:0]            r_cache_instr_type, w_cache_instr_type_n;
    logic [31:0]           r_cache_data_out, w_cache_data_out_n;
    logic                  r_mem_req, w_mem_req_n;
    logic [7:0]            r_mem_dout, w_mem_dout_n;
    logic [ADDR_WIDTH-1:0] r_mem_a, w_mem_a_n;
    logic                  r_mem_wr, w_mem_wr_n;

    logic                  w_is_store;
    logic                  w_is_io;
    logic                  w_is_io_req;
    logic                  w_io_stall;
    logic                  w_io_single;
    logic [2:0]            w_nbytes_req;
    logic [1:0]            w_cap_idx;
    logic [1:0]            w_st_idx;
    logic [31:0]           w_cap;

    assign w_is_store  = (r_type == C_TYPE_STORE);
    assign w_is_io     = (r_addr[IO_BASE_BIT -: 2] == 2'b11);
    assign w_is_io_req = (data_addr_in[IO_BASE_BIT -: 2] == 2'b11);

`ifdef IO_STALL_EN
    assign w_io_stall  = w_is_store && w_is_io && io_buffer_full;
    assign w_io_single = (instr_type_in != C_TYPE_STORE) && w_is_io_req;
`else
    logic w_unused_io;
    assign w_io_stall  = 1'b0;
    assign w_io_single = 1'b0;
    assign w_unused_io = io_buffer_full ^ w_is_io ^ w_is_io_req;
`endif

    // During a load, RAM data lags the address by one cycle.
    // At the edge that processes byte counter k, mem_din holds byte k-1.
    assign w_cap_idx = 2'(r_k - 3'd1);
    assign w_st_idx  = 2'(r_k + 3'd1);

    always_comb begin
        w_cap = r_bytes;
        w_cap[8*w_cap_idx +: 8] = mem_din;
    end

    always_comb begin
        case (op_in[1:0])
            2'b00:   w_nbytes_req = 3'd1;
            2'b01:   w_nbytes_req = 3'd2;
            default: w_nbytes_req = 3'd4;
        endcase
        if (w_io_single) begin
            w_nbytes_req = 3'd1;
        end
    end

    // Extension is keyed on the number of bytes actually transferred.
    // This lets a single-byte IO halfword load extend from bit 7.
    function automatic logic [31:0] f_extend(input logic [31:0] w,
                                             input logic [2:0]  n,
                                             input logic        sgn);
        logic [31:0] v;
        case (n)
            3'd1:    v = {{24{sgn & w[7]}}, w[7:0]};
            3'd2:    v = {{16{sgn & w[15]}}, w[15:0]};
            default: v = w;
        endcase
        return v;
    endfunction

    always_comb begin
        w_state_n            = r_state;
        w_op_n               = r_op;
        w_type_n             = r_type;
        w_addr_n             = r_addr;
        w_data_n             = r_data;
        w_nbytes_n           = r_nbytes;
        w_k_n                = r_k;
        w_bytes_n            = r_bytes;
        w_cache_ready_n      = 1'b0;
        w_cache_instr_type_n = r_cache_instr_type;
        w_cache_data_out_n   = r_cache_data_out;
        w_mem_req_n          = r_mem_req;
        w_mem_dout_n         = r_mem_dout;
        w_mem_a_n            = r_mem_a;
        w_mem_wr_n           = r_mem_wr;

        case (r_state)
            S_IDLE: begin
                if (in_lsb_ready && !rob_clear) begin
                    w_op_n      = op_in;
                    w_type_n    = instr_type_in;
                    w_addr_n    = data_addr_in;
                    w_data_n    = data_in;
                    w_nbytes_n  = w_nbytes_req;
                    w_k_n       = 3'd0;
                    w_bytes_n   = 32'd0;
                    w_mem_req_n = 1'b1;
                    w_state_n   = S_WAIT_GNT;
                end
            end
            S_WAIT_GNT: begin
                if (rob_clear) begin
                    w_mem_req_n = 1'b0;
                    w_state_n   = S_IDLE;
                end else if (mem_gnt && !w_io_stall) begin
                    w_k_n     = 3'd0;
                    w_mem_a_n = r_addr;
                    w_state_n = S_XFER;
                    if (w_is_store) begin
                        w_mem_wr_n   = 1'b1;
                        w_mem_dout_n = r_data[7:0];
                    end else begin
                        w_mem_wr_n = 1'b0;
                    end
                end
            end
            S_XFER: begin
                if (w_is_store) begin
                    // A committed store always runs to completion,
                    // even if rob_clear is asserted.
                    if (r_k == r_nbytes - 3'd1) begin
                        w_mem_wr_n           = 1'b0;
                        w_mem_a_n            = '0;
                        w_cache_ready_n      = 1'b1;
                        w_cache_data_out_n   = 32'd0;
                        w_cache_instr_type_n = r_type;
                        w_state_n            = S_DONE;
                    end else begin
                        w_k_n        = r_k + 3'd1;
                        w_mem_a_n    = r_addr + ADDR_WIDTH'(r_k + 3'd1);
                        w_mem_dout_n = r_data[8*w_st_idx +: 8];
                    end
                end else if (rob_clear) begin
                    w_mem_req_n = 1'b0;
                    w_mem_a_n   = '0;
                    w_state_n   = S_IDLE;
                end else begin
                    if (r_k != 3'd0) begin
                        w_bytes_n = w_cap;
                    end
                    if (r_k == r_nbytes) begin
                        w_cache_data_out_n   = f_extend(w_cap, r_nbytes, ~r_op[2]);
                        w_cache_ready_n      = 1'b1;
                        w_cache_instr_type_n = r_type;
                        w_state_n            = S_DONE;
                    end else if (r_k == r_nbytes - 3'd1) begin
                        // The last address has been issued. Park the bus
                        // while the final byte arrives.
                        w_mem_a_n = '0;
                        w_k_n     = r_k + 3'd1;
                    end else begin
                        w_mem_a_n = r_addr + ADDR_WIDTH'(r_k + 3'd1);
                        w_k_n     = r_k + 3'd1;
                    end
                end
            end
            S_DONE: begin
                w_mem_req_n = 1'b0;
                w_state_n   = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state            <= S_IDLE;
            r_op               <= 3'd0;
            r_type             <= 7'd0;
            r_addr             <= '0;
            r_data             <= 32'd0;
            r_nbytes           <= 3'd0;
            r_k                <= 3'd0;
            r_bytes            <= 32'd0;
            r_cache_ready      <= 1'b0;
            r_cache_instr_type <= 7'd0;
            r_cache_data_out   <= 32'd0;
            r_mem_req          <= 1'b0;
            r_mem_dout         <= 8'd0;
            r_mem_a            <= '0;
            r_mem_wr           <= 1'b0;
        end else if (rdy) begin
            r_state            <= w_state_n;
            r_op               <= w_op_n;
            r_type             <= w_type_n;
            r_addr             <= w_addr_n;
            r_data             <= w_data_n;
            r_nbytes           <= w_nbytes_n;
            r_k                <= w_k_n;
            r_bytes            <= w_bytes_n;
            r_cache_ready      <= w_cache_ready_n;
            r_cache_instr_type <= w_cache_instr_type_n;
            r_cache_data_out   <= w_cache_data_out_n;
            r_mem_req          <= w_mem_req_n;
            r_mem_dout         <= w_mem_dout_n;
            r_mem_a            <= w_mem_a_n;
            r_mem_wr           <= w_mem_wr_n;
        end
    end

    assign welcome_lsb      = rst && (r_state == S_IDLE);
    assign cache_ready      = r_cache_ready;
    assign cache_instr_type = r_cache_instr_type;
    assign cache_data_out   = r_cache_data_out;
    assign mem_req          = r_mem_req;
    assign mem_dout         = r_mem_dout;
    assign mem_a            = r_mem_a;
    assign mem_wr           = r_mem_wr;

endmodule
`default_nettype wire
